// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and constants for the forwarding scoreboard.
package fwd_scoreboard_pkg;

    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned STAGE_IDX_W = 4;
    localparam int unsigned SEL_RF      = 0;

    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    // One tracked pipeline stage: does it write a register, which one, and from
    // which stage (1-based) its result can be forwarded.
    typedef struct packed {
        logic                   valid;
        logic [REG_ADDR_W-1:0]  rd;
        logic [STAGE_IDX_W-1:0] rdy_stage;
    } stage_entry_t;

endpackage

// File: rtl/fwd_scoreboard_if.sv
// ID-side bundle between the decode stage and the forwarding scoreboard.
interface fwd_scoreboard_if
    import fwd_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_RD_PORTS   = 2,
    parameter int unsigned NUM_FWD_STAGES = 2,
    parameter int unsigned MAX_PENDING    = 4
) ();

    localparam int unsigned SEL_W = $clog2(NUM_FWD_STAGES + 1);
    localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1);

    logic                               id_valid;
    logic [NUM_RD_PORTS*REG_ADDR_W-1:0] id_rs_addr;
    logic [NUM_RD_PORTS-1:0]            id_rs_used;
    logic [REG_ADDR_W-1:0]              id_rd_addr;
    logic                               id_rd_wen;
    logic                               id_is_load;
    logic                               id_is_long;
    logic                               flush;
    logic                               lu_done_valid;
    logic [REG_ADDR_W-1:0]              lu_done_rd;
    logic [NUM_RD_PORTS*SEL_W-1:0]      fwd_sel;
    logic                               stall;
    logic [CNT_W-1:0]                   pending_cnt;

    modport master (
        output id_valid, id_rs_addr, id_rs_used, id_rd_addr, id_rd_wen,
               id_is_load, id_is_long, flush, lu_done_valid, lu_done_rd,
        input  fwd_sel, stall, pending_cnt
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rs_used, id_rd_addr, id_rd_wen,
               id_is_load, id_is_long, flush, lu_done_valid, lu_done_rd,
        output fwd_sel, stall, pending_cnt
    );

endinterface

// File: rtl/fwd_stage_match.sv
// Finds the youngest tracked stage writing a given source register.
module fwd_stage_match
    import fwd_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_FWD_STAGES = 2
) (
    input  logic [REG_ADDR_W-1:0]           i_rs,
    input  stage_entry_t [NUM_FWD_STAGES-1:0] i_stages,
    output logic                            o_hit,
    output logic [STAGE_IDX_W-1:0]          o_stage,
    output logic                            o_not_ready
);

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        o_hit       = 1'b0;
        o_stage     = '0;
        o_not_ready = 1'b0;
        for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
            if (i_stages[k].valid && (i_stages[k].rd == i_rs)) begin
                o_hit       = 1'b1;
                o_stage     = STAGE_IDX_W'(k + 1);
                o_not_ready = (STAGE_IDX_W'(k + 1) < i_stages[k].rdy_stage);
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding-select and ID-stall generation with a scoreboard for
// variable-latency producers.
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_RD_PORTS     = 2,
    parameter int unsigned NUM_FWD_STAGES   = 2,
    parameter int unsigned LOAD_READY_STAGE = 2,
    parameter int unsigned MAX_PENDING      = 4
) (
    input logic             clk,
    input logic             rst_n,
    fwd_scoreboard_if.slave io_bus
);

    localparam int unsigned SEL_W = $clog2(NUM_FWD_STAGES + 1);
    localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1);
    localparam stage_entry_t BUBBLE = '0;

    stage_entry_t [NUM_FWD_STAGES-1:0] r_stages;
    logic [31:0]                       r_pending;
    logic [CNT_W-1:0]                  r_pending_cnt;

    logic [NUM_RD_PORTS-1:0]       w_hit;
    logic [NUM_RD_PORTS-1:0]       w_not_ready;
    logic [NUM_RD_PORTS-1:0]       w_port_stall;
    logic [STAGE_IDX_W-1:0]        w_match_stage [NUM_RD_PORTS];
    logic [NUM_RD_PORTS*SEL_W-1:0] w_fwd_sel;

    logic         w_waw;
    logic         w_cap;
    logic         w_stall;
    logic         w_advance;
    logic         w_set;
    logic         w_clr_hit;
    logic         w_dec;
    stage_entry_t w_new_entry;
    logic [31:0]  w_pending_d;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        logic [REG_ADDR_W-1:0] w_rs;
        logic                  w_active;

        assign w_rs     = io_bus.id_rs_addr[REG_ADDR_W*p +: REG_ADDR_W];
        assign w_active = io_bus.id_valid & io_bus.id_rs_used[p] & (w_rs != X0);

        fwd_stage_match #(
            .NUM_FWD_STAGES (NUM_FWD_STAGES)
        ) u_match (
            .i_rs        (w_rs),
            .i_stages    (r_stages),
            .o_hit       (w_hit[p]),
            .o_stage     (w_match_stage[p]),
            .o_not_ready (w_not_ready[p])
        );

        // A matching stage decides on its own; the scoreboard only matters
        // when nothing in the shadow pipeline writes this register.
        assign w_port_stall[p] = w_active & (w_hit[p] ? w_not_ready[p] : r_pending[w_rs]);
        assign w_fwd_sel[SEL_W*p +: SEL_W] = (w_active & w_hit[p] & ~w_not_ready[p]) ?
                                             SEL_W'(w_match_stage[p]) : SEL_W'(SEL_RF);
    end

    assign w_waw   = io_bus.id_valid & io_bus.id_rd_wen & r_pending[io_bus.id_rd_addr];
    assign w_cap   = io_bus.id_valid & io_bus.id_is_long &
                     (r_pending_cnt == CNT_W'(MAX_PENDING));
    assign w_stall = ~io_bus.flush & ((|w_port_stall) | w_waw | w_cap);

    assign w_advance = io_bus.id_valid & ~w_stall & ~io_bus.flush;

    // Long ops never forward from the shadow pipeline; the scoreboard owns them.
    assign w_new_entry.valid     = io_bus.id_rd_wen & (io_bus.id_rd_addr != X0) &
                                   ~io_bus.id_is_long;
    assign w_new_entry.rd        = io_bus.id_rd_addr;
    assign w_new_entry.rdy_stage = io_bus.id_is_load ? STAGE_IDX_W'(LOAD_READY_STAGE) :
                                                       STAGE_IDX_W'(1);

    assign w_set = w_advance & io_bus.id_is_long & io_bus.id_rd_wen &
                   (io_bus.id_rd_addr != X0);
    // A done for the register being set this cycle still consumes one count,
    // so the +1/-1 cancel even though set wins on the bit.
    assign w_clr_hit = io_bus.lu_done_valid &
                       (r_pending[io_bus.lu_done_rd] |
                        (w_set & (io_bus.lu_done_rd == io_bus.id_rd_addr)));
    assign w_dec     = w_clr_hit & ((r_pending_cnt != '0) | w_set);

    // Next pending bits: clear first so a same-register set wins.
    always_comb begin
        w_pending_d = r_pending;
        if (io_bus.lu_done_valid) begin
            w_pending_d[io_bus.lu_done_rd] = 1'b0;
        end
        if (w_set) begin
            w_pending_d[io_bus.id_rd_addr] = 1'b1;
        end
    end

    // Shadow pipeline: stage1 loads or bubbles, older stages shift unconditionally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stages <= '0;
        end else begin
            r_stages[0] <= w_advance ? w_new_entry : BUBBLE;
            for (int k = 1; k < NUM_FWD_STAGES; k++) begin
                r_stages[k] <= ((k == 1) && io_bus.flush) ? BUBBLE : r_stages[k-1];
            end
        end
    end

    // Scoreboard bits and outstanding-op counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending     <= '0;
            r_pending_cnt <= '0;
        end else begin
            r_pending     <= w_pending_d;
            r_pending_cnt <= r_pending_cnt + CNT_W'(w_set) - CNT_W'(w_dec);
        end
    end

    assign io_bus.fwd_sel     = w_fwd_sel;
    assign io_bus.stall       = w_stall;
    assign io_bus.pending_cnt = r_pending_cnt;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios plus random traffic
// against a queue-style reference model.
module tb_fwd_scoreboard;

    localparam int NP   = 2;
    localparam int NS   = 2;
    localparam int LRS  = 2;
    localparam int MAXP = 4;

    logic clk;
    logic rst_n;

    fwd_scoreboard_if #(
        .NUM_RD_PORTS   (NP),
        .NUM_FWD_STAGES (NS),
        .MAX_PENDING    (MAXP)
    ) bus ();

    fwd_scoreboard #(
        .NUM_RD_PORTS     (NP),
        .NUM_FWD_STAGES   (NS),
        .LOAD_READY_STAGE (LRS),
        .MAX_PENDING      (MAXP)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model state: in-flight producers per stage and outstanding long ops.
    bit m_v   [NS];
    int m_rd  [NS];
    int m_rdy [NS];
    bit m_pend[32];
    int m_cnt;
    bit exp_stall;
    int exp_sel [NP];

    function automatic void model_reset();
        for (int k = 0; k < NS; k++) begin
            m_v[k] = 0; m_rd[k] = 0; m_rdy[k] = 1;
        end
        for (int r = 0; r < 32; r++) m_pend[r] = 0;
        m_cnt = 0;
    endfunction

    function automatic void model_eval();
        int  rs;
        bit  found;
        exp_stall = 0;
        for (int p = 0; p < NP; p++) begin
            exp_sel[p] = 0;
            rs = int'(bus.id_rs_addr[p*5 +: 5]);
            if (bus.id_valid && bus.id_rs_used[p] && rs != 0) begin
                found = 0;
                for (int k = 0; k < NS; k++) begin
                    if (!found && m_v[k] && m_rd[k] == rs) begin
                        found = 1;
                        if (k + 1 >= m_rdy[k]) exp_sel[p] = k + 1;
                        else exp_stall = 1;
                    end
                end
                if (!found && m_pend[rs]) exp_stall = 1;
            end
        end
        if (bus.id_valid && bus.id_rd_wen && m_pend[int'(bus.id_rd_addr)]) exp_stall = 1;
        if (bus.id_valid && bus.id_is_long && m_cnt == MAXP) exp_stall = 1;
        if (bus.flush) exp_stall = 0;
    endfunction

    function automatic void model_update();
        bit adv, set, hit;
        int rd, dr;
        rd  = int'(bus.id_rd_addr);
        dr  = int'(bus.lu_done_rd);
        adv = bus.id_valid && !exp_stall && !bus.flush;
        for (int k = NS - 1; k >= 1; k--) begin
            m_v[k]   = (k == 1 && bus.flush) ? 1'b0 : m_v[k-1];
            m_rd[k]  = m_rd[k-1];
            m_rdy[k] = m_rdy[k-1];
        end
        m_v[0]   = adv && bus.id_rd_wen && rd != 0 && !bus.id_is_long;
        m_rd[0]  = rd;
        m_rdy[0] = bus.id_is_load ? LRS : 1;
        set = adv && bus.id_is_long && bus.id_rd_wen && rd != 0;
        hit = bus.lu_done_valid && (m_pend[dr] || (set && dr == rd));
        if (bus.lu_done_valid) m_pend[dr] = 0;
        if (set) begin
            m_pend[rd] = 1;
            m_cnt++;
        end
        if (hit && m_cnt > 0) m_cnt--;
    endfunction

    task automatic sample();
        @(negedge clk);
        model_eval();
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        bus.id_valid = 0; bus.id_rs_addr = '0; bus.id_rs_used = '0;
        bus.id_rd_addr = '0; bus.id_rd_wen = 0; bus.id_is_load = 0;
        bus.id_is_long = 0; bus.flush = 0; bus.lu_done_valid = 0; bus.lu_done_rd = '0;
    endtask

    task automatic issue(input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used,
                         input logic [4:0] rd, input logic wen, input logic ld,
                         input logic lng);
        idle();
        bus.id_valid = 1; bus.id_rs_addr = {rs1, rs0}; bus.id_rs_used = used;
        bus.id_rd_addr = rd; bus.id_rd_wen = wen; bus.id_is_load = ld; bus.id_is_long = lng;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        issue(5'd5, 5'd6, 2'b11, 5'd7, 1, 0, 0);
        sample();
        n_vec++;
        if (bus.stall !== 1'b0) begin
            n_err++; $display("FAIL reset_stall: got %0b want 0", bus.stall);
        end
        n_vec++;
        if (bus.fwd_sel !== 4'd0) begin
            n_err++; $display("FAIL reset_fwd_sel: got %0d want 0", bus.fwd_sel);
        end
        n_vec++;
        if (bus.pending_cnt !== 3'd0) begin
            n_err++; $display("FAIL reset_cnt: got %0d want 0", bus.pending_cnt);
        end
        step();
        idle(); sample(); step();
    endtask

    task automatic test_alu_fwd();
        issue(5'd1, 5'd2, 2'b11, 5'd12, 1, 0, 0);
        sample(); step();
        issue(5'd12, 5'd3, 2'b11, 5'd13, 1, 0, 0);
        sample();
        n_vec++;
        if (bus.fwd_sel[1:0] !== 2'd1 || bus.stall !== 1'b0) begin
            n_err++;
            $display("FAIL alu_stage1: got sel=%0d stall=%0b want sel=1 stall=0",
                     bus.fwd_sel[1:0], bus.stall);
        end
        step();
        issue(5'd12, 5'd0, 2'b01, 5'd0, 0, 0, 0);
        sample();
        n_vec++;
        if (bus.fwd_sel[1:0] !== 2'd2 || bus.stall !== 1'b0) begin
            n_err++;
            $display("FAIL alu_stage2: got sel=%0d stall=%0b want sel=2 stall=0",
                     bus.fwd_sel[1:0], bus.stall);
        end
        step();
    endtask

    task automatic test_load_use();
        issue(5'd1, 5'd0, 2'b01, 5'd2, 1, 1, 0);
        sample(); step();
        issue(5'd2, 5'd5, 2'b11, 5'd3, 1, 0, 0);
        sample();
        n_vec++;
        if (bus.stall !== 1'b1 || bus.fwd_sel[1:0] !== 2'd0) begin
            n_err++;
            $display("FAIL load_use_stall: got stall=%0b sel=%0d want stall=1 sel=0",
                     bus.stall, bus.fwd_sel[1:0]);
        end
        step();
        sample();
        n_vec++;
        if (bus.stall !== 1'b0 || bus.fwd_sel[1:0] !== 2'd2) begin
            n_err++;
            $display("FAIL load_use_fwd: got stall=%0b sel=%0d want stall=0 sel=2",
                     bus.stall, bus.fwd_sel[1:0]);
        end
        step();
    endtask

    task automatic test_long_op();
        issue(5'd1, 5'd0, 2'b01, 5'd7, 1, 0, 1);
        sample(); step();
        issue(5'd7, 5'd0, 2'b01, 5'd8, 1, 0, 0);
        sample();
        n_vec++;
        if (bus.stall !== 1'b1 || bus.pending_cnt !== 3'd1) begin
            n_err++;
            $display("FAIL long_pending: got stall=%0b cnt=%0d want stall=1 cnt=1",
                     bus.stall, bus.pending_cnt);
        end
        step();
        bus.lu_done_valid = 1; bus.lu_done_rd = 5'd7;
        sample();
        n_vec++;
        if (bus.stall !== 1'b1) begin
            n_err++; $display("FAIL long_done_cycle: got stall=%0b want 1", bus.stall);
        end
        step();
        bus.lu_done_valid = 0;
        sample();
        n_vec++;
        if (bus.stall !== 1'b0 || bus.fwd_sel[1:0] !== 2'd0 || bus.pending_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL long_release: got stall=%0b sel=%0d cnt=%0d want 0 0 0",
                     bus.stall, bus.fwd_sel[1:0], bus.pending_cnt);
        end
        step();
    endtask

    task automatic test_x0_capacity();
        issue(5'd1, 5'd0, 2'b01, 5'd0, 1, 0, 0);
        sample(); step();
        issue(5'd0, 5'd0, 2'b11, 5'd3, 1, 0, 0);
        sample();
        n_vec++;
        if (bus.fwd_sel !== 4'd0 || bus.stall !== 1'b0) begin
            n_err++;
            $display("FAIL x0_source: got sel=%0d stall=%0b want 0 0", bus.fwd_sel, bus.stall);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            issue(5'd0, 5'd0, 2'b00, 5'(20 + i), 1, 0, 1);
            sample(); step();
        end
        issue(5'd0, 5'd0, 2'b00, 5'd24, 1, 0, 1);
        sample();
        n_vec++;
        if (bus.stall !== 1'b1 || bus.pending_cnt !== 3'd4) begin
            n_err++;
            $display("FAIL capacity_full: got stall=%0b cnt=%0d want stall=1 cnt=4",
                     bus.stall, bus.pending_cnt);
        end
        step();
        bus.lu_done_valid = 1; bus.lu_done_rd = 5'd20;
        sample(); step();
        bus.lu_done_valid = 0;
        sample();
        n_vec++;
        if (bus.stall !== 1'b0 || bus.pending_cnt !== 3'd3) begin
            n_err++;
            $display("FAIL capacity_free: got stall=%0b cnt=%0d want stall=0 cnt=3",
                     bus.stall, bus.pending_cnt);
        end
        step();
        for (int i = 21; i <= 24; i++) begin
            idle();
            bus.lu_done_valid = 1; bus.lu_done_rd = 5'(i);
            sample(); step();
        end
        idle();
        sample();
        n_vec++;
        if (bus.pending_cnt !== 3'd0) begin
            n_err++; $display("FAIL capacity_drain: got cnt=%0d want 0", bus.pending_cnt);
        end
        step();
    endtask

    task automatic test_flush_same_cycle();
        issue(5'd1, 5'd0, 2'b01, 5'd9, 1, 0, 0);
        sample(); step();
        issue(5'd2, 5'd0, 2'b01, 5'd10, 1, 0, 0);
        bus.flush = 1;
        sample();
        n_vec++;
        if (bus.stall !== 1'b0) begin
            n_err++; $display("FAIL flush_stall: got %0b want 0", bus.stall);
        end
        step();
        issue(5'd9, 5'd10, 2'b11, 5'd11, 1, 0, 0);
        sample();
        n_vec++;
        if (bus.fwd_sel !== 4'd0 || bus.stall !== 1'b0) begin
            n_err++;
            $display("FAIL flush_bubble: got sel=%0d stall=%0b want 0 0", bus.fwd_sel, bus.stall);
        end
        step();
        issue(5'd0, 5'd0, 2'b00, 5'd4, 1, 0, 1);
        bus.lu_done_valid = 1; bus.lu_done_rd = 5'd4;
        sample(); step();
        issue(5'd4, 5'd0, 2'b01, 5'd5, 1, 0, 0);
        sample();
        n_vec++;
        if (bus.stall !== 1'b1 || bus.pending_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL set_wins: got stall=%0b cnt=%0d want stall=1 cnt=0",
                     bus.stall, bus.pending_cnt);
        end
        step();
        idle();
        bus.lu_done_valid = 1; bus.lu_done_rd = 5'd4;
        sample(); step();
        issue(5'd4, 5'd0, 2'b01, 5'd5, 1, 0, 0);
        sample();
        n_vec++;
        if (bus.stall !== 1'b0 || bus.pending_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL no_underflow: got stall=%0b cnt=%0d want stall=0 cnt=0",
                     bus.stall, bus.pending_cnt);
        end
        step();
        idle(); sample(); step();
    endtask

    task automatic test_reset_mid_stall();
        issue(5'd0, 5'd0, 2'b00, 5'd10, 1, 0, 1);
        sample(); step();
        issue(5'd0, 5'd0, 2'b00, 5'd11, 1, 0, 1);
        sample(); step();
        issue(5'd10, 5'd0, 2'b01, 5'd12, 1, 0, 0);
        sample();
        n_vec++;
        if (bus.stall !== 1'b1 || bus.pending_cnt !== 3'd2) begin
            n_err++;
            $display("FAIL pre_reset: got stall=%0b cnt=%0d want stall=1 cnt=2",
                     bus.stall, bus.pending_cnt);
        end
        rst_n = 0;
        #1;
        n_vec++;
        if (bus.stall !== 1'b0 || bus.pending_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL async_reset: got stall=%0b cnt=%0d want stall=0 cnt=0",
                     bus.stall, bus.pending_cnt);
        end
        model_reset();
        @(posedge clk);
        #1;
        issue(5'd10, 5'd11, 2'b11, 5'd12, 1, 0, 0);
        rst_n = 1;
        sample();
        n_vec++;
        if (bus.fwd_sel !== 4'd0 || bus.stall !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset: got sel=%0d stall=%0b want 0 0", bus.fwd_sel, bus.stall);
        end
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            idle();
            bus.id_valid = ($urandom_range(3) != 0);
            bus.id_rs_addr = {5'($urandom_range(7)), 5'($urandom_range(7))};
            bus.id_rs_used = 2'($urandom_range(3));
            bus.id_rd_addr = 5'($urandom_range(7));
            if (bus.id_valid) begin
                bus.id_rd_wen  = ($urandom_range(3) != 0);
                bus.id_is_load = ($urandom_range(3) == 0);
                bus.id_is_long = ($urandom_range(7) == 0);
            end
            bus.flush = ($urandom_range(9) == 0);
            bus.lu_done_valid = ($urandom_range(3) == 0);
            bus.lu_done_rd = 5'($urandom_range(7));
            sample();
            n_vec++;
            if (bus.stall !== exp_stall) begin
                n_err++; $display("FAIL rand_stall[%0d]: got %0b want %0b", i, bus.stall, exp_stall);
            end
            for (int p = 0; p < NP; p++) begin
                n_vec++;
                if (int'(bus.fwd_sel[p*2 +: 2]) !== exp_sel[p]) begin
                    n_err++;
                    $display("FAIL rand_sel%0d[%0d]: got %0d want %0d",
                             p, i, bus.fwd_sel[p*2 +: 2], exp_sel[p]);
                end
            end
            n_vec++;
            if (int'(bus.pending_cnt) !== m_cnt) begin
                n_err++;
                $display("FAIL rand_cnt[%0d]: got %0d want %0d", i, bus.pending_cnt, m_cnt);
            end
            step();
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_long_op();
        test_x0_capacity();
        test_flush_same_cycle();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
Parametrised successor to the fixed three-stage forwarding unit. It keeps its own shadow of the in-flight destination registers for NUM_FWD_STAGES pipeline stages after ID, and adds a scoreboard for variable-latency producers such as the iterative multiplier and loads that miss. Each cycle it gives every ID read port a forwarding select and produces a single ID stall signal. It sits beside the ID stage and drives the operand muxes that feed the ALU, branch comparator and store data paths.

Parameters:
NUM_RD_PORTS, 2, number of ID source operands checked.
NUM_FWD_STAGES, 2, number of tracked stages after ID (1 = EXM, 2 = WB, ...).
LOAD_READY_STAGE, 2, first stage index (1-based) at which a load result can be forwarded.
MAX_PENDING, 4, maximum number of outstanding long-latency operations.
SEL_W, $clog2(NUM_FWD_STAGES+1), width of each forwarding select.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs_addr  in  NUM_RD_PORTS*5  source register addresses, port p at bits [5p+4:5p]
id_rs_used  in  NUM_RD_PORTS  source port p is actually read
id_rd_addr  in  5  destination register
id_rd_wen  in  1  instruction writes rd
id_is_load  in  1  result becomes ready at LOAD_READY_STAGE
id_is_long  in  1  variable-latency op, completes via the done interface
flush  in  1  kill the instruction in ID and the stage-1 entry
lu_done_valid  in  1  a long-latency op has written back
lu_done_rd  in  5  register written by that op
fwd_sel  out  NUM_RD_PORTS*SEL_W  per port: 0 = register file, k = stage k
stall  out  1  hold ID/IF and insert a bubble into stage 1
pending_cnt  out  $clog2(MAX_PENDING+1)  number of outstanding long ops

Behaviour:
- Reset (asynchronous, rst_n=0): all stage entries invalid, pending[31:0]=0, pending_cnt=0. Combinational consequences: stall=0, fwd_sel=0.
- Stage entry fields: {valid, rd, rdy_stage}.
- advance = id_valid & ~stall & ~flush. On advance, stage1 takes {id_rd_wen & (id_rd_addr!=0) & ~id_is_long, id_rd_addr, id_is_load ? LOAD_READY_STAGE : 1}. Otherwise stage1 takes a bubble (valid=0).
- Stages k>1 always shift from stage k-1 every cycle; stall never freezes them.
- flush: the stage1 entry is invalidated in the same edge as it shifts to stage2, so stage2 receives a bubble. The scoreboard is untouched. When flush=1, stall=0.
- Outputs are combinational from state and ID inputs, so they are valid in the same cycle (zero latency).
- Per port p, when id_valid & id_rs_used[p] & rs!=0:
  - Find the youngest (lowest k) valid stage with rd==rs.
  - If a match is found and k>=rdy_stage: fwd_sel=k.
  - If a match is found and k<rdy_stage: load-use hazard, stall=1, fwd_sel=0.
  - If no stage matches and pending[rs]=1: stall=1.
  - If no stage matches and the register is not pending: fwd_sel=0.
- rs==x0 or id_rs_used[p]=0: fwd_sel=0 and no stall contribution from that port.
- WAW: id_rd_wen & pending[id_rd_addr] gives stall=1.
- Capacity: id_is_long & (pending_cnt==MAX_PENDING) gives stall=1.
- Scoreboard set: on advance with id_is_long & id_rd_wen & rd!=0, set pending[rd].
- Scoreboard clear: lu_done_valid clears pending[lu_done_rd].
- Same reg set and cleared in one cycle: set wins; pending_cnt is unchanged (+1 and -1).
- lu_done_valid for a register that is not pending: ignored, pending_cnt unchanged (no underflow).
- Completion forwarding: lu_done is not forwarded. The consumer stalls until pending clears, then reads the register file the next cycle; the register file must be write-first.
- Stall does not feed back into the shift registers, so there is no combinational loop.

Decomposition:
- Shared package: REG_ADDR_W=5, the X0 constant, the stage-entry struct/field widths, the fwd_sel encoding (SEL_RF=0).
- One natural sub-module: fwd_stage_match. It is combinational: it takes one rs and all stage entries, and returns hit, stage index and not_ready. It is instantiated NUM_RD_PORTS times.
- Scoreboard and counter stay in the top module.

Test Plan:
1. ALU to ALU (add x12 then and using x12 next cycle): stage1 rd=12 rdy=1 -> fwd_sel[0]=1, stall=0. Next cycle the same rs sees stage2 -> fwd_sel=2.
2. Load-use (lw x2 then add x3,x2,x5): cycle 1 -> stall=1, fwd_sel=0. Cycle 2, entry now in stage2 -> stall=0, fwd_sel[0]=2.
3. Long op to x7, then consumer of x7: stall=1 while pending[7]. Assert lu_done_valid with rd=7 -> pending_cnt 1->0, next cycle stall=0, fwd_sel=0.
4. x0 source with stage1 rd=0 from addi x0: fwd_sel=0, stall=0. Issue 4 long ops, then a 5th -> pending_cnt=4, stall=1 until one done.
5. flush with ALU op in ID writing x9, then consumer of x9: stage2 invalid, fwd_sel=0. Same-cycle issue of long op to x4 plus lu_done_rd=4 -> pending[4]=1, cnt unchanged.
6. Reset asserted mid-stall with pending_cnt=2 -> immediately stall=0, cnt=0. After release, the first instruction reads fwd_sel=0.
